// File: rtl/cdr_phase_ctrl.sv
// rtl/cdr_phase_ctrl.sv - CDR phase-selection controller: vote integration, phase stepping, settle hold, lock.
module cdr_phase_ctrl #(
    parameter int N_PHASES = 4,
    parameter int PH_W     = 2,
    parameter int ACC_W    = 6,
    parameter int THRESH   = 8,
    parameter int HOLD_CYC = 4,
    parameter int LOCK_CNT = 16
) (
    input  logic            clk_in,
    input  logic            rst,
    input  logic            en,
    input  logic            pd_valid,
    input  logic            pd_early,
    input  logic            pd_late,
    output logic [PH_W-1:0] phase_sel,
    output logic            step_pulse,
    output logic            step_dir,
    output logic            slip,
    output logic            locked
);
    localparam int LK_W = $clog2(LOCK_CNT + 1);
    localparam int HD_W = $clog2(HOLD_CYC + 1);
    localparam int AMAX = (1 << (ACC_W - 1)) - 1;

    localparam logic signed [ACC_W:0]   SUM_MAX = (ACC_W + 1)'(AMAX);
    localparam logic signed [ACC_W:0]   SUM_MIN = -SUM_MAX;
    localparam logic signed [ACC_W-1:0] THR_P   = ACC_W'(THRESH);
    localparam logic signed [ACC_W-1:0] THR_N   = -THR_P;

    typedef enum logic [1:0] {IDLE, TRACK, STEP, HOLD} state_t;

    state_t                  state_q;
    logic [PH_W-1:0]         phase_q;
    logic signed [ACC_W-1:0] acc_q;
    logic [LK_W-1:0]         lock_cnt_q;
    logic [HD_W-1:0]         hold_cnt_q;
    logic                    dir_q;
    logic                    step_pulse_q, step_dir_q, slip_q, locked_q;

    logic signed [1:0]       vote;
    logic signed [ACC_W:0]   acc_sum;
    logic signed [ACC_W-1:0] acc_d;
    logic [LK_W-1:0]         lock_cnt_d;
    logic [PH_W-1:0]         phase_d;
    logic                    cross_up, cross_dn, wrap;

    always_comb begin
        vote = 2'sd0;
        if (pd_late && !pd_early) begin
            vote = 2'sd1;
        end else if (pd_early && !pd_late) begin
            vote = -2'sd1;
        end
        // One extra bit of headroom so saturation is detected before it can wrap.
        acc_sum = {acc_q[ACC_W-1], acc_q} + {{(ACC_W - 1){vote[1]}}, vote};
        if (acc_sum > SUM_MAX) begin
            acc_d = SUM_MAX[ACC_W-1:0];
        end else if (acc_sum < SUM_MIN) begin
            acc_d = SUM_MIN[ACC_W-1:0];
        end else begin
            acc_d = acc_sum[ACC_W-1:0];
        end
        cross_up   = (acc_d >= THR_P);
        cross_dn   = (acc_d <= THR_N);
        lock_cnt_d = (lock_cnt_q == LK_W'(LOCK_CNT)) ? lock_cnt_q : lock_cnt_q + 1'b1;
        phase_d    = dir_q ? phase_q + 1'b1 : phase_q - 1'b1;
        wrap       = dir_q ? (phase_q == PH_W'(N_PHASES - 1)) : (phase_q == '0);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            acc_q        <= '0;
            lock_cnt_q   <= '0;
            hold_cnt_q   <= '0;
            dir_q        <= 1'b0;
            step_pulse_q <= 1'b0;
            step_dir_q   <= 1'b0;
            slip_q       <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            step_pulse_q <= 1'b0;
            slip_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (en) state_q <= TRACK;
                end
                TRACK: begin
                    if (en && pd_valid) begin
                        if (cross_up || cross_dn) begin
                            dir_q   <= cross_up;
                            state_q <= STEP;
                        end else begin
                            acc_q      <= acc_d;
                            lock_cnt_q <= lock_cnt_d;
                            if (lock_cnt_d == LK_W'(LOCK_CNT)) locked_q <= 1'b1;
                        end
                    end
                end
                // STEP ignores en so a step already committed always completes.
                STEP: begin
                    phase_q      <= phase_d;
                    step_pulse_q <= 1'b1;
                    step_dir_q   <= dir_q;
                    slip_q       <= wrap;
                    acc_q        <= '0;
                    lock_cnt_q   <= '0;
                    locked_q     <= 1'b0;
                    hold_cnt_q   <= HD_W'(HOLD_CYC);
                    state_q      <= HOLD;
                end
                HOLD: begin
                    if (en) begin
                        if (hold_cnt_q <= HD_W'(1)) begin
                            hold_cnt_q <= '0;
                            state_q    <= TRACK;
                        end else begin
                            hold_cnt_q <= hold_cnt_q - 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign phase_sel  = phase_q;
    assign step_pulse = step_pulse_q;
    assign step_dir   = step_dir_q;
    assign slip       = slip_q;
    assign locked     = locked_q;
endmodule

// File: tb/tb_cdr_phase_ctrl.sv
// tb/tb_cdr_phase_ctrl.sv - directed and randomized self-checking bench for cdr_phase_ctrl.
module tb_cdr_phase_ctrl;
    logic       clk_in = 1'b0;
    logic       rst = 1'b1, en = 1'b0, pd_valid = 1'b0, pd_early = 1'b0, pd_late = 1'b0;
    logic [1:0] phase_sel;
    logic       step_pulse, step_dir, slip, locked;

    int n_cmp = 0;
    int n_fail = 0;
    bit chk = 0;

    // Behavioural reference: plain integers, updated once per rising edge.
    int m_phase = 0, m_acc = 0, m_lk = 0, m_hold = 0;
    bit m_started = 0, m_pend = 0, m_pdir = 0;
    bit m_step = 0, m_dir = 0, m_slip = 0, m_locked = 0;

    cdr_phase_ctrl dut (
        .clk_in(clk_in), .rst(rst), .en(en), .pd_valid(pd_valid),
        .pd_early(pd_early), .pd_late(pd_late), .phase_sel(phase_sel),
        .step_pulse(step_pulse), .step_dir(step_dir), .slip(slip), .locked(locked)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk_in) begin
        int v, a;
        m_step = 0;
        m_slip = 0;
        if (rst) begin
            m_phase = 0; m_acc = 0; m_lk = 0; m_hold = 0;
            m_started = 0; m_pend = 0; m_pdir = 0;
            m_dir = 0; m_locked = 0;
            chk = 1;
        end else if (m_pend) begin
            m_pend = 0;
            m_step = 1;
            m_dir  = m_pdir;
            m_slip = m_pdir ? (m_phase == 3) : (m_phase == 0);
            m_phase = (m_phase + (m_pdir ? 1 : 3)) % 4;
            m_acc = 0; m_lk = 0; m_locked = 0;
            m_hold = 4;
        end else if (!en) begin
        end else if (!m_started) begin
            m_started = 1;
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (pd_valid) begin
            v = (pd_late && !pd_early) ? 1 : ((pd_early && !pd_late) ? -1 : 0);
            a = m_acc + v;
            if (a > 31) a = 31;
            if (a < -31) a = -31;
            if (a >= 8) begin
                m_pend = 1; m_pdir = 1;
            end else if (a <= -8) begin
                m_pend = 1; m_pdir = 0;
            end else begin
                m_acc = a;
                if (m_lk < 16) m_lk++;
                if (m_lk == 16) m_locked = 1;
            end
        end
    end

    always @(negedge clk_in) begin
        if (chk) begin
            check("phase_sel", 32'(phase_sel), 32'(m_phase));
            check("step_pulse", 32'(step_pulse), 32'(m_step));
            check("step_dir", 32'(step_dir), 32'(m_dir));
            check("slip", 32'(slip), 32'(m_slip));
            check("locked", 32'(locked), 32'(m_locked));
        end
    end

    task automatic tick(input bit r, input bit e, input bit v, input bit ea, input bit la);
        rst = r; en = e; pd_valid = v; pd_early = ea; pd_late = la;
        @(posedge clk_in);
        #1;
    endtask

    task automatic start();
        tick(1, 1, 0, 0, 0);
        tick(1, 1, 0, 0, 0);
        tick(0, 1, 0, 0, 0);
    endtask

    task automatic votes(input int n, input bit ea, input bit la);
        for (int i = 0; i < n; i++) tick(0, 1, 1, ea, la);
    endtask

    initial begin
        bit seen;
        // 1: idle loop with no votes
        start();
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick(0, 1, 0, 0, 0);
            seen |= step_pulse;
        end
        check("t1_phase", 32'(phase_sel), 0);
        check("t1_locked", 32'(locked), 0);
        check("t1_no_step", 32'(seen), 0);

        // 2: eight late votes step up, hold lasts four cycles
        votes(8, 0, 1);
        check("t2_pre_step", 32'(step_pulse), 0);
        votes(1, 0, 1);
        check("t2_phase", 32'(phase_sel), 1);
        check("t2_pulse", 32'(step_pulse), 1);
        check("t2_dir", 32'(step_dir), 1);
        check("t2_slip", 32'(slip), 0);
        votes(4, 0, 1);
        votes(8, 0, 1);
        check("t2_hold_len", 32'(step_pulse), 0);
        votes(1, 0, 1);
        check("t2_second_step", 32'(step_pulse), 1);
        check("t2_phase2", 32'(phase_sel), 2);

        // 3: early votes wrap 0 -> 3, then 3 -> 2
        start();
        votes(9, 1, 0);
        check("t3_phase", 32'(phase_sel), 3);
        check("t3_dir", 32'(step_dir), 0);
        check("t3_slip", 32'(slip), 1);
        for (int i = 0; i < 4; i++) tick(0, 1, 0, 0, 0);
        votes(9, 1, 0);
        check("t3_phase2", 32'(phase_sel), 2);
        check("t3_slip2", 32'(slip), 0);

        // 4: balanced votes reach lock on the 16th, a step drops it
        start();
        for (int i = 0; i < 16; i++) begin
            case (i % 4)
                0: tick(0, 1, 1, 0, 1);
                1: tick(0, 1, 1, 1, 0);
                2: tick(0, 1, 1, 1, 1);
                default: tick(0, 1, 1, 0, 0);
            endcase
            if (i == 14) check("t4_not_yet", 32'(locked), 0);
        end
        check("t4_locked", 32'(locked), 1);
        check("t4_no_step", 32'(phase_sel), 0);
        votes(9, 0, 1);
        check("t4_step", 32'(step_pulse), 1);
        check("t4_unlock", 32'(locked), 0);

        // 5: en low freezes the accumulator
        start();
        votes(7, 0, 1);
        for (int i = 0; i < 10; i++) tick(0, 0, 1, 0, 1);
        check("t5_frozen", 32'(phase_sel), 0);
        votes(1, 0, 1);
        tick(0, 1, 0, 0, 0);
        check("t5_step", 32'(step_pulse), 1);
        check("t5_phase", 32'(phase_sel), 1);

        // 6: reset mid-HOLD
        start();
        votes(9, 0, 1);
        for (int i = 0; i < 4; i++) tick(0, 1, 0, 0, 0);
        votes(9, 0, 1);
        check("t6_phase2", 32'(phase_sel), 2);
        tick(0, 1, 1, 0, 1);
        tick(1, 1, 1, 0, 1);
        check("t6_rst_phase", 32'(phase_sel), 0);
        check("t6_rst_locked", 32'(locked), 0);
        check("t6_rst_pulse", 32'(step_pulse), 0);
        tick(0, 1, 0, 0, 0);
        votes(9, 0, 1);
        check("t6_phase", 32'(phase_sel), 1);

        // Randomized segments with a per-segment vote bias
        for (int seg = 0; seg < 40; seg++) begin
            int mode;
            mode = $urandom_range(0, 2);
            for (int c = 0; c < 80; c++) begin
                bit r, e, v, ea, la;
                r = ($urandom_range(0, 299) == 0);
                e = ($urandom_range(0, 9) != 0);
                v = $urandom_range(0, 1);
                case (mode)
                    0: begin la = ($urandom_range(0, 3) != 0); ea = ($urandom_range(0, 3) == 0); end
                    1: begin ea = ($urandom_range(0, 3) != 0); la = ($urandom_range(0, 3) == 0); end
                    default: begin ea = $urandom_range(0, 1); la = $urandom_range(0, 1); end
                endcase
                tick(r, e, v, ea, la);
            end
        end

        @(negedge clk_in);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
